uart_sync_fifo: RTL and testbench

UART_SYNC_FIFO -- requirements
Module: uart_sync_fifo

---
 rtl/uart_pkg.sv | 17 +
 rtl/uart_fifo_ram.sv | 35 +++
 rtl/uart_sync_fifo.sv | 106 ++++++++++
 tb/tb_uart_sync_fifo.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART constants and the FIFO occupancy-count type used by the
// rxd/txd datapaths and the synchronous FIFO.
package uart_pkg;

  localparam int UART_WIDTH      = 8;
  localparam int UART_FIFO_DEPTH = 16;

  // Occupancy needs one bit more than the address so that DEPTH itself fits.
  function automatic int count_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  localparam int UART_COUNT_W = count_w(UART_FIFO_DEPTH);

  typedef logic [UART_COUNT_W-1:0] uart_count_t;

endpackage

// File: rtl/uart_fifo_ram.sv
// Simple dual-port storage for the UART FIFO: one synchronous write port and
// one synchronous read port whose output register only loads on a read.
module uart_fifo_ram #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             srst,
  input  logic             wr_en,
  input  logic [AW-1:0]    wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_en,
  input  logic [AW-1:0]    rd_addr,
  output logic [WIDTH-1:0] rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  // The array itself is never reset so it can map onto RAM primitives.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  always_ff @(posedge clk) begin
    if (srst) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= mem[rd_addr];
    end
  end

endmodule

// File: rtl/uart_sync_fifo.sv
// Single-clock UART FIFO with standard read latency, registered occupancy
// flags and one-cycle acknowledge / error pulses.
module uart_sync_fifo
  import uart_pkg::*;
#(
  parameter int WIDTH    = UART_WIDTH,
  parameter int DEPTH    = UART_FIFO_DEPTH,
  parameter int AF_LEVEL = DEPTH - 2
) (
  input  logic                      clk,
  input  logic                      srst,
  input  logic [WIDTH-1:0]          din,
  input  logic                      wr_en,
  input  logic                      rd_en,
  output logic [WIDTH-1:0]          dout,
  output logic                      valid,
  output logic                      wr_ack,
  output logic                      overflow,
  output logic                      underflow,
  output logic                      full,
  output logic                      empty,
  output logic                      almost_full,
  output logic [count_w(DEPTH)-1:0] data_count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = count_w(DEPTH);

  localparam logic [AW:0]   PTR_ONE = {{AW{1'b0}}, 1'b1};
  localparam logic [CW-1:0] CNT_ONE = {{(CW-1){1'b0}}, 1'b1};
  localparam logic [CW-1:0] AF_CNT  = CW'(AF_LEVEL);

  logic [AW:0]   wr_ptr, rd_ptr;
  logic [AW:0]   wr_ptr_nxt, rd_ptr_nxt;
  logic [CW-1:0] count_nxt;
  logic          wr_ok, rd_ok;
  logic          full_nxt, empty_nxt;

  // Flags are registered, so acceptance only depends on state, never on din.
  assign wr_ok = wr_en && !full;
  assign rd_ok = rd_en && !empty;

  always_comb begin
    wr_ptr_nxt = wr_ptr;
    rd_ptr_nxt = rd_ptr;
    count_nxt  = data_count;
    if (wr_ok) begin
      wr_ptr_nxt = wr_ptr + PTR_ONE;
    end
    if (rd_ok) begin
      rd_ptr_nxt = rd_ptr + PTR_ONE;
    end
    case ({wr_ok, rd_ok})
      2'b10:   count_nxt = data_count + CNT_ONE;
      2'b01:   count_nxt = data_count - CNT_ONE;
      default: count_nxt = data_count;
    endcase
  end

  // Same address with differing wrap bits means the writer lapped the reader.
  assign empty_nxt = (wr_ptr_nxt == rd_ptr_nxt);
  assign full_nxt  = (wr_ptr_nxt[AW] != rd_ptr_nxt[AW]) &&
                     (wr_ptr_nxt[AW-1:0] == rd_ptr_nxt[AW-1:0]);

  always_ff @(posedge clk) begin
    if (srst) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      data_count  <= '0;
      full        <= 1'b0;
      empty       <= 1'b1;
      almost_full <= 1'b0;
      valid       <= 1'b0;
      wr_ack      <= 1'b0;
      overflow    <= 1'b0;
      underflow   <= 1'b0;
    end else begin
      wr_ptr      <= wr_ptr_nxt;
      rd_ptr      <= rd_ptr_nxt;
      data_count  <= count_nxt;
      full        <= full_nxt;
      empty       <= empty_nxt;
      almost_full <= (count_nxt >= AF_CNT);
      valid       <= rd_ok;
      wr_ack      <= wr_ok;
      overflow    <= wr_en && full;
      underflow   <= rd_en && empty;
    end
  end

  uart_fifo_ram #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk     (clk),
    .srst    (srst),
    .wr_en   (wr_ok && !srst),
    .wr_addr (wr_ptr[AW-1:0]),
    .wr_data (din),
    .rd_en   (rd_ok && !srst),
    .rd_addr (rd_ptr[AW-1:0]),
    .rd_data (dout)
  );

endmodule

// File: tb/tb_uart_sync_fifo.sv
// Directed bench for uart_sync_fifo: basic traffic, full/empty corner cases
// and a scoreboarded random stream interrupted by a reset.
module tb_uart_sync_fifo;

  logic       clk = 1'b0;
  logic       srst;
  logic [7:0] din;
  logic       wr_en, rd_en;
  logic [7:0] dout;
  logic       valid, wr_ack, overflow, underflow;
  logic       full, empty, almost_full;
  logic [4:0] data_count;

  int compared   = 0;
  int mismatched = 0;

  logic [7:0] q[$];
  logic [7:0] exp_d;
  logic       w, r, f, e, wok, rok;
  logic [7:0] d;

  uart_sync_fifo dut (
    .clk         (clk),
    .srst        (srst),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .valid       (valid),
    .wr_ack      (wr_ack),
    .overflow    (overflow),
    .underflow   (underflow),
    .full        (full),
    .empty       (empty),
    .almost_full (almost_full),
    .data_count  (data_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Drive one cycle of inputs, then sample 1 time unit after the edge.
  task automatic step(input logic sw, input logic sr, input logic [7:0] sd, input logic rs);
    wr_en = sw;
    rd_en = sr;
    din   = sd;
    srst  = rs;
    @(posedge clk);
    #1;
    wr_en = 1'b0;
    rd_en = 1'b0;
    srst  = 1'b0;
  endtask

  initial begin
    srst = 1'b1; wr_en = 1'b0; rd_en = 1'b0; din = 8'h00;
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    step(1'b1, 1'b1, 8'hEE, 1'b1);
    chk("rst_empty", 32'(empty), 32'd1);
    chk("rst_full", 32'(full), 32'd0);
    chk("rst_af", 32'(almost_full), 32'd0);
    chk("rst_count", 32'(data_count), 32'd0);
    chk("rst_dout", 32'(dout), 32'h00);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_wr_ack", 32'(wr_ack), 32'd0);
    chk("rst_ovf", 32'(overflow), 32'd0);
    chk("rst_udf", 32'(underflow), 32'd0);

    // Three writes straight after reset
    step(1'b1, 1'b0, 8'h11, 1'b0);
    chk("wr1_ack", 32'(wr_ack), 32'd1);
    chk("wr1_empty", 32'(empty), 32'd0);
    step(1'b1, 1'b0, 8'h22, 1'b0);
    chk("wr2_ack", 32'(wr_ack), 32'd1);
    step(1'b1, 1'b0, 8'h33, 1'b0);
    chk("wr3_ack", 32'(wr_ack), 32'd1);
    chk("wr3_count", 32'(data_count), 32'd3);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("idle_ack", 32'(wr_ack), 32'd0);
    chk("idle_valid", 32'(valid), 32'd0);

    // Three reads
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rd1_valid", 32'(valid), 32'd1);
    chk("rd1_dout", 32'(dout), 32'h11);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rd2_dout", 32'(dout), 32'h22);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rd3_valid", 32'(valid), 32'd1);
    chk("rd3_dout", 32'(dout), 32'h33);
    chk("rd3_empty", 32'(empty), 32'd1);
    chk("rd3_count", 32'(data_count), 32'd0);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("hold_dout", 32'(dout), 32'h33);
    chk("hold_valid", 32'(valid), 32'd0);

    // Fill to DEPTH, watching almost_full and full
    for (int i = 0; i < 16; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0);
      chk($sformatf("fill%0d_count", i), 32'(data_count), 32'(i + 1));
      chk($sformatf("fill%0d_af", i), 32'(almost_full), (i + 1 >= 14) ? 32'd1 : 32'd0);
      chk($sformatf("fill%0d_full", i), 32'(full), (i + 1 == 16) ? 32'd1 : 32'd0);
    end
    step(1'b1, 1'b0, 8'hAA, 1'b0);
    chk("ovf_pulse", 32'(overflow), 32'd1);
    chk("ovf_ack", 32'(wr_ack), 32'd0);
    chk("ovf_count", 32'(data_count), 32'd16);
    step(1'b0, 1'b0, 8'h00, 1'b0);
    chk("ovf_once", 32'(overflow), 32'd0);

    // Simultaneous read/write at full: read wins, write rejected
    step(1'b1, 1'b1, 8'h55, 1'b0);
    chk("rwfull_dout", 32'(dout), 32'h00);
    chk("rwfull_valid", 32'(valid), 32'd1);
    chk("rwfull_ovf", 32'(overflow), 32'd1);
    chk("rwfull_count", 32'(data_count), 32'd15);
    chk("rwfull_full", 32'(full), 32'd0);
    for (int i = 1; i < 16; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk($sformatf("drain%0d_dout", i), 32'(dout), 32'(i));
    end
    chk("drain_empty", 32'(empty), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("udf_pulse", 32'(underflow), 32'd1);
    chk("udf_valid", 32'(valid), 32'd0);
    chk("udf_hold", 32'(dout), 32'h0F);

    // Simultaneous read/write at empty: write wins, read rejected
    step(1'b1, 1'b1, 8'h77, 1'b0);
    chk("rwempty_udf", 32'(underflow), 32'd1);
    chk("rwempty_valid", 32'(valid), 32'd0);
    chk("rwempty_ack", 32'(wr_ack), 32'd1);
    chk("rwempty_count", 32'(data_count), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("rwempty_next", 32'(dout), 32'h77);
    chk("rwempty_drained", 32'(empty), 32'd1);

    // Random stream with a reset in the middle
    q.delete();
    for (int i = 0; i < 40; i++) begin
      if (i == 20) begin
        step(1'b1, 1'b1, 8'hC3, 1'b1);
        q.delete();
        chk("mid_rst_empty", 32'(empty), 32'd1);
        chk("mid_rst_count", 32'(data_count), 32'd0);
        chk("mid_rst_valid", 32'(valid), 32'd0);
        chk("mid_rst_dout", 32'(dout), 32'h00);
        continue;
      end
      w   = ($urandom_range(0, 3) != 0);
      r   = 1'($urandom_range(0, 1));
      d   = 8'($urandom_range(0, 255));
      f   = (q.size() == 16);
      e   = (q.size() == 0);
      wok = w && !f;
      rok = r && !e;
      step(w, r, d, 1'b0);
      if (rok) begin
        exp_d = q.pop_front();
        chk($sformatf("rnd%0d_dout", i), 32'(dout), 32'(exp_d));
      end
      if (wok) q.push_back(d);
      chk($sformatf("rnd%0d_valid", i), 32'(valid), 32'(rok));
      chk($sformatf("rnd%0d_ack", i), 32'(wr_ack), 32'(wok));
      chk($sformatf("rnd%0d_udf", i), 32'(underflow), 32'(r && e));
      chk($sformatf("rnd%0d_count", i), 32'(data_count), 32'(q.size()));
    end
    while (q.size() != 0) begin
      exp_d = q.pop_front();
      step(1'b0, 1'b1, 8'h00, 1'b0);
      chk("final_drain_dout", 32'(dout), 32'(exp_d));
    end
    step(1'b0, 1'b1, 8'h00, 1'b0);
    chk("final_udf", 32'(underflow), 32'd1);
    chk("final_empty", 32'(empty), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
